// File: rtl/color_sequencer.sv
// One-hot light sequencer: a button rise steps NUM_CH channels in order, each held dwell+1 cycles.
// Optional input debounce filter is enabled by defining COLOR_SEQ_DEBOUNCE_EN.
module color_sequencer #(
  parameter int NUM_CH          = 3,
  parameter int DWELL_W         = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      button,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      mode_loop,
  input  logic                      abort,
  output logic [NUM_CH-1:0]         ch_out,
  output logic [$clog2(NUM_CH)-1:0] step_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] FIRST_CH = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic btn;
  logic btn_q;
  logic rise;

`ifdef COLOR_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;

  // The filtered level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      btn    <= 1'b0;
    end else if (button != btn) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn    <= button;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign btn = button;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign rise = btn & ~btn_q;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_q_n;
  logic               loop_q, loop_q_n;
  logic               stop_pend, stop_pend_n;
  logic [NUM_CH-1:0]  ch_n;
  logic               busy_n;
  logic               done_n;
  logic               stop_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dwell_q   <= '0;
      loop_q    <= 1'b0;
      stop_pend <= 1'b0;
      ch_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      dwell_q   <= dwell_q_n;
      loop_q    <= loop_q_n;
      stop_pend <= stop_pend_n;
      ch_out    <= ch_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // A stop request raised on the very cycle a pass ends still ends that pass.
  assign stop_req = stop_pend | (rise & loop_q);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    dwell_q_n   = dwell_q;
    loop_q_n    = loop_q;
    stop_pend_n = stop_pend;
    ch_n        = ch_out;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (!abort && rise) begin
          state_n     = ACTIVE;
          dwell_q_n   = dwell;
          loop_q_n    = mode_loop;
          idx_n       = '0;
          cnt_n       = '0;
          stop_pend_n = 1'b0;
          ch_n        = FIRST_CH;
          busy_n      = 1'b1;
        end
      end

      ACTIVE: begin
        if (abort) begin
          state_n     = IDLE;
          idx_n       = '0;
          cnt_n       = '0;
          stop_pend_n = 1'b0;
          ch_n        = '0;
          busy_n      = 1'b0;
        end else begin
          stop_pend_n = stop_req;
          if (cnt == dwell_q) begin
            cnt_n = '0;
            if (idx != LAST_IDX) begin
              idx_n = idx + 1'b1;
              ch_n  = ch_out << 1;
            end else if (loop_q && !stop_req) begin
              idx_n = '0;
              ch_n  = FIRST_CH;
            end else begin
              state_n     = IDLE;
              idx_n       = '0;
              stop_pend_n = 1'b0;
              ch_n        = '0;
              busy_n      = 1'b0;
              done_n      = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign step_idx = idx;

endmodule

// File: tb/tb_color_sequencer.sv
// Randomised scoreboard bench for color_sequencer, with a schedule-queue reference model.
// Define COLOR_SEQ_DEBOUNCE_EN to model the input filter as well.
module tb_color_sequencer;

  localparam int NUM_CH  = 3;
  localparam int DWELL_W = 8;
  localparam int DEB     = 4;
  localparam int IDX_W   = $clog2(NUM_CH);

  logic               clk = 1'b0;
  logic               reset;
  logic               button;
  logic [DWELL_W-1:0] dwell;
  logic               mode_loop;
  logic               abort;
  logic [NUM_CH-1:0]  ch_out;
  logic [IDX_W-1:0]   step_idx;
  logic               busy;
  logic               done;

  color_sequencer #(
    .NUM_CH(NUM_CH),
    .DWELL_W(DWELL_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .dwell(dwell),
    .mode_loop(mode_loop),
    .abort(abort),
    .ch_out(ch_out),
    .step_idx(step_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] ch;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a running sequence is a queue of channel numbers, one entry per cycle.
  bit m_running, m_loop, m_stop, m_prev;
  int m_dwell, m_cur;
  int m_plan[$];
  bit m_filt;
  int m_fcnt;

  task automatic fill_pass();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k <= m_dwell; k++)
        m_plan.push_back(c);
  endtask

  task automatic model_reset();
    m_running = 0; m_loop = 0; m_stop = 0; m_prev = 0;
    m_dwell = 0; m_cur = 0; m_filt = 0; m_fcnt = 0;
    m_plan.delete();
  endtask

  task automatic model_step(output exp_t e);
    bit b, rise;
    b = button;
`ifdef COLOR_SEQ_DEBOUNCE_EN
    b = m_filt;
    if (button != m_filt) begin
      m_fcnt++;
      if (m_fcnt == DEB) begin
        m_filt = button;
        m_fcnt = 0;
      end
    end else begin
      m_fcnt = 0;
    end
`endif
    rise = b && !m_prev;
    m_prev = b;
    e.done = 1'b0;
    if (abort) begin
      m_running = 0;
      m_stop = 0;
      m_plan.delete();
    end else if (m_running) begin
      if (rise && m_loop) m_stop = 1;
      if (m_plan.size() == 0) begin
        if (m_loop && !m_stop) begin
          fill_pass();
        end else begin
          m_running = 0;
          m_stop = 0;
          e.done = 1'b1;
        end
      end
      if (m_running) m_cur = m_plan.pop_front();
    end else if (rise) begin
      m_running = 1;
      m_loop = mode_loop;
      m_dwell = int'(dwell);
      m_stop = 0;
      fill_pass();
      m_cur = m_plan.pop_front();
    end
    e.ch   = m_running ? NUM_CH'(1 << m_cur) : '0;
    e.idx  = m_running ? IDX_W'(m_cur) : '0;
    e.busy = m_running;
  endtask

  task automatic apply_stimulus(input logic b, input logic ab, input logic [DWELL_W-1:0] d,
                                input logic ml);
    exp_t e;
    @(negedge clk);
    button = b; abort = ab; dwell = d; mode_loop = ml;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input logic [DWELL_W-1:0] d, input logic ml);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, d, ml);
  endtask

  task automatic check_output(input string name, input exp_t e);
    tests++;
    if (ch_out !== e.ch || step_idx !== e.idx || busy !== e.busy || done !== e.done) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got ch=%b idx=%0d busy=%b done=%b, expected ch=%b idx=%0d busy=%b done=%b",
               name, $time, ch_out, step_idx, busy, done, e.ch, e.idx, e.busy, e.done);
    end
    tests++;
    if (!$onehot0(ch_out) || busy !== (ch_out != '0)) begin
      fails++;
      $display("[TB] FAIL invariant @%0t: got ch=%b busy=%b, expected one-hot-or-zero with busy=(ch!=0)",
               $time, ch_out, busy);
    end
  endtask

  // Monitor: every output sample after an active edge is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("seq", e);
      end
    end
  end

  task automatic reset_check(input string name);
    exp_t z;
    z = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_output(name, z);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    reset = 1'b1; button = 1'b0; abort = 1'b0; dwell = '0; mode_loop = 1'b0;
    model_reset();
    #1 check_output("reset_state", z);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_cycles(2, 8'd0, 1'b0);

    // One-shot, dwell 2
    apply_stimulus(1'b1, 1'b0, 8'd2, 1'b0);
    idle_cycles(12, 8'd2, 1'b0);

    // Loop with dwell 0, stop request during channel 1 of the second pass
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b1);
    idle_cycles(3, 8'd0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 8'd0, 1'b1);
    idle_cycles(6, 8'd0, 1'b1);

    // Abort in the fourth cycle of channel 1, then restart
    apply_stimulus(1'b1, 1'b0, 8'd5, 1'b0);
    idle_cycles(8, 8'd5, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'd5, 1'b0);
    idle_cycles(3, 8'd5, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd5, 1'b0);
    idle_cycles(20, 8'd5, 1'b0);

    // Button held across completion while dwell changes underneath
    apply_stimulus(1'b1, 1'b0, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0, 8'd9, 1'b0);
    idle_cycles(2, 8'd1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd1, 1'b0);
    idle_cycles(8, 8'd1, 1'b0);

    // Abort coinciding with a rise in IDLE must not start
    apply_stimulus(1'b1, 1'b1, 8'd1, 1'b0);
    idle_cycles(3, 8'd1, 1'b0);

    // Asynchronous reset while channel 1 is lit
    apply_stimulus(1'b1, 1'b0, 8'd3, 1'b0);
    idle_cycles(5, 8'd3, 1'b0);
    reset_check("reset_mid_step");
    idle_cycles(3, 8'd3, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'd3, 1'b0);
    idle_cycles(14, 8'd3, 1'b0);

    // Debounce-style glitch then a longer hold
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    idle_cycles(5, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 8'd0, 1'b0);
    idle_cycles(12, 8'd0, 1'b0);

    // Maximum dwell: each channel held 256 cycles
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, 8'd255, 1'b0);
    idle_cycles(3 * 256 + 4, 8'd255, 1'b0);

    // Randomised traffic
    begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 5) == 0) b = ~b;
        apply_stimulus(b, ($urandom_range(0, 79) == 0), DWELL_W'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));
      end
    end
    idle_cycles(20, 8'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
